// File: rtl/rvx_board_pkg.sv
// Shared types and helpers for the RVX board clock/reset conditioner.
package rvx_board_pkg;

    typedef enum logic [1:0] {
        RST_ACTIVE = 2'd0,
        RST_HOLD   = 2'd1,
        RST_RUN    = 2'd2
    } rst_state_t;

    // Bits needed to hold values 0..max_value, never less than one.
    function automatic int unsigned counter_width(input int unsigned max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/rvx_button_debouncer.sv
// One button path: two-flop synchroniser, stability debouncer and press pulse.
module rvx_button_debouncer
    import rvx_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic button_debounced,
    output logic button_pressed
);

    localparam int unsigned    CW       = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_level;
    logic [CW-1:0] stable_count;
    logic          settle;

    // Synced level has differed for DEBOUNCE_CYCLES consecutive cycles.
    assign settle = (sync_level != button_debounced) && (stable_count == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta        <= 1'b0;
            sync_level       <= 1'b0;
            stable_count     <= '0;
            button_debounced <= 1'b0;
            button_pressed   <= 1'b0;
        end else begin
            sync_meta      <= button_raw;
            sync_level     <= sync_meta;
            button_pressed <= settle && sync_level;
            if ((sync_level == button_debounced) || settle) begin
                stable_count <= '0;
            end else begin
                stable_count <= stable_count + CW'(1);
            end
            if (settle) begin
                button_debounced <= sync_level;
            end
        end
    end

endmodule

// File: rtl/rvx_board_conditioner.sv
// Board-pin front end: even clock divider, debounced buttons and a SoC reset
// stretcher aligned to the divided clock.
module rvx_board_conditioner
    import rvx_board_pkg::*;
#(
    parameter int unsigned CLOCK_DIVIDE         = 2,
    parameter int unsigned BUTTON_COUNT         = 4,
    parameter int unsigned DEBOUNCE_CYCLES      = 50000,
    parameter int unsigned RESET_BUTTON_INDEX   = 0,
    parameter int unsigned RESET_STRETCH_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BUTTON_COUNT-1:0] button_raw,
    output logic                    clock_divided,
    output logic                    clock_divided_rise,
    output logic [BUTTON_COUNT-1:0] button_debounced,
    output logic [BUTTON_COUNT-1:0] button_pressed,
    output logic                    soc_reset_n
);

    localparam int unsigned              HALF_PERIOD  = CLOCK_DIVIDE / 2;
    localparam int unsigned              DIV_W        = counter_width(HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0]         DIV_LAST     = DIV_W'(HALF_PERIOD - 1);
    localparam int unsigned              STRETCH_W    = counter_width(RESET_STRETCH_CYCLES - 1);
    localparam logic [STRETCH_W-1:0]     STRETCH_LAST = STRETCH_W'(RESET_STRETCH_CYCLES - 1);

    logic [DIV_W-1:0]     div_count;
    logic                 div_terminal;
    logic                 clock_divided_fall;
    rst_state_t           rst_state;
    logic [STRETCH_W-1:0] stretch_count;
    logic                 reset_button;

    assign div_terminal       = (div_count == DIV_LAST);
    // Reset gating only matters for divide-by-2, where the terminal count is 0.
    assign clock_divided_rise = div_terminal && !clock_divided && !reset;
    assign clock_divided_fall = div_terminal && clock_divided;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_count     <= '0;
            clock_divided <= 1'b0;
        end else if (div_terminal) begin
            div_count     <= '0;
            clock_divided <= ~clock_divided;
        end else begin
            div_count     <= div_count + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < BUTTON_COUNT; i++) begin : g_button
        rvx_button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock            (clock),
            .reset            (reset),
            .button_raw       (button_raw[i]),
            .button_debounced (button_debounced[i]),
            .button_pressed   (button_pressed[i])
        );
    end

    assign reset_button = button_debounced[RESET_BUTTON_INDEX];

    // Advancing only on fall strobes keeps soc_reset_n stable at every divided rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_state     <= RST_ACTIVE;
            stretch_count <= '0;
            soc_reset_n   <= 1'b0;
        end else if (clock_divided_fall) begin
            case (rst_state)
                RST_ACTIVE: begin
                    if (!reset_button) begin
                        rst_state     <= RST_HOLD;
                        stretch_count <= '0;
                    end
                end
                RST_HOLD: begin
                    if (reset_button) begin
                        rst_state <= RST_ACTIVE;
                    end else if (stretch_count == STRETCH_LAST) begin
                        rst_state   <= RST_RUN;
                        soc_reset_n <= 1'b1;
                    end else begin
                        stretch_count <= stretch_count + STRETCH_W'(1);
                    end
                end
                RST_RUN: begin
                    if (reset_button) begin
                        rst_state   <= RST_ACTIVE;
                        soc_reset_n <= 1'b0;
                    end
                end
                default: begin
                    rst_state   <= RST_ACTIVE;
                    soc_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvx_board_conditioner.sv
// Self-checking bench for rvx_board_conditioner with small divide/debounce/stretch values.
module tb_rvx_board_conditioner;

    localparam int unsigned CD  = 4;
    localparam int unsigned BC  = 4;
    localparam int unsigned DC  = 8;
    localparam int unsigned RBI = 0;
    localparam int unsigned RSC = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [BC-1:0] button_raw = '0;
    logic          clock_divided;
    logic          clock_divided_rise;
    logic [BC-1:0] button_debounced;
    logic [BC-1:0] button_pressed;
    logic          soc_reset_n;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    rvx_board_conditioner #(
        .CLOCK_DIVIDE         (CD),
        .BUTTON_COUNT         (BC),
        .DEBOUNCE_CYCLES      (DC),
        .RESET_BUTTON_INDEX   (RBI),
        .RESET_STRETCH_CYCLES (RSC)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .button_raw         (button_raw),
        .clock_divided      (clock_divided),
        .clock_divided_rise (clock_divided_rise),
        .button_debounced   (button_debounced),
        .button_pressed     (button_pressed),
        .soc_reset_n        (soc_reset_n)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    // First cycle >= c (negedge-sampled) in which the fall strobe is active.
    function automatic int next_strobe(input int c);
        int s;
        s = c;
        for (int n = 0; n < 8; n++) begin
            if (((s - rel_cyc) % 4) == 3) return s;
            s = s + 1;
        end
        return s;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        button_raw = '0;
        repeat (3) @(negedge clock);
        checks++; if (clock_divided !== 1'b0) begin failures++; $display("FAIL reset_clock_divided: got %b expected 0", clock_divided); end
        checks++; if (clock_divided_rise !== 1'b0) begin failures++; $display("FAIL reset_rise: got %b expected 0", clock_divided_rise); end
        checks++; if (button_debounced !== '0) begin failures++; $display("FAIL reset_debounced: got %b expected 0", button_debounced); end
        checks++; if (button_pressed !== '0) begin failures++; $display("FAIL reset_pressed: got %b expected 0", button_pressed); end
        checks++; if (soc_reset_n !== 1'b0) begin failures++; $display("FAIL reset_soc_reset_n: got %b expected 0", soc_reset_n); end
    endtask

    task automatic test_reset_release();
        int   exp_q[$];
        int   k;
        logic prev_soc, prev_cd, e_cd, e_rise;
        @(negedge clock);
        reset = 1'b0;
        rel_cyc = cyc;
        exp_q.push_back(rel_cyc + 16);
        prev_soc = soc_reset_n;
        prev_cd  = clock_divided;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            k = cyc - rel_cyc;
            e_cd   = ((k / 2) % 2) == 1;
            e_rise = (k % 4) == 1;
            checks++; if (clock_divided !== e_cd) begin failures++; $display("FAIL release_clock_divided k=%0d: got %b expected %b", k, clock_divided, e_cd); end
            checks++; if (clock_divided_rise !== e_rise) begin failures++; $display("FAIL release_rise k=%0d: got %b expected %b", k, clock_divided_rise, e_rise); end
            if (soc_reset_n !== prev_soc) begin
                checks++;
                if (soc_reset_n !== 1'b1 || exp_q.size() == 0) begin
                    failures++; $display("FAIL release_soc_unexpected: got %b at cycle %0d expected no change", soc_reset_n, cyc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (cyc != e) begin failures++; $display("FAIL release_soc_rise_cycle: got %0d expected %0d", cyc, e); end
                end
            end
            if (prev_cd == 1'b0 && clock_divided == 1'b1) begin
                checks++; if (soc_reset_n !== prev_soc) begin failures++; $display("FAIL soc_stable_at_divided_rise: got %b expected %b", soc_reset_n, prev_soc); end
            end
            prev_soc = soc_reset_n;
            prev_cd  = clock_divided;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL release_soc_timeout: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checks++; if (button_debounced[1] !== 1'b0) begin failures++; $display("FAIL glitch_debounced i=%0d: got %b expected 0", i, button_debounced[1]); end
            checks++; if (button_pressed[1] !== 1'b0) begin failures++; $display("FAIL glitch_pressed i=%0d: got %b expected 0", i, button_pressed[1]); end
            if (i == 0) button_raw[1] = 1'b1;
            if (i == 7) button_raw[1] = 1'b0;
        end
        checks++; if (soc_reset_n !== 1'b1) begin failures++; $display("FAIL glitch_soc_reset_n: got %b expected 1", soc_reset_n); end
    endtask

    task automatic test_clean_press();
        int   exp_q[$];
        int   p;
        logic e_deb;
        @(negedge clock);
        p = cyc;
        button_raw[2] = 1'b1;
        exp_q.push_back(p + 10);
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            e_deb = (cyc >= p + 10) && (cyc < p + 30);
            checks++; if (button_debounced[2] !== e_deb) begin failures++; $display("FAIL press_debounced cycle=%0d: got %b expected %b", cyc - p, button_debounced[2], e_deb); end
            if (button_pressed[2] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL press_extra_pulse: got pulse at %0d expected none", cyc - p);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (cyc != e) begin failures++; $display("FAIL press_pulse_cycle: got %0d expected %0d", cyc - p, e - p); end
                end
            end
            if (cyc == p + 20) button_raw[2] = 1'b0;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL press_pulse_timeout: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_runtime_reset_button();
        int   fall_q[$];
        int   rise_q[$];
        int   p;
        logic prev_soc;
        @(negedge clock);
        p = cyc;
        button_raw[0] = 1'b1;
        fall_q.push_back(next_strobe(p + 10) + 1);
        prev_soc = soc_reset_n;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (soc_reset_n !== prev_soc) begin
                int e;
                checks++;
                if (soc_reset_n === 1'b0) begin
                    if (fall_q.size() == 0) begin failures++; $display("FAIL runtime_unexpected_fall: got fall at %0d expected none", cyc - p); end
                    else begin e = fall_q.pop_front(); if (cyc != e) begin failures++; $display("FAIL runtime_fall_cycle: got %0d expected %0d", cyc - p, e - p); end end
                end else begin
                    if (rise_q.size() == 0) begin failures++; $display("FAIL runtime_unexpected_rise: got rise at %0d expected none", cyc - p); end
                    else begin e = rise_q.pop_front(); if (cyc != e) begin failures++; $display("FAIL runtime_rise_cycle: got %0d expected %0d", cyc - p, e - p); end end
                end
            end
            prev_soc = soc_reset_n;
            if (cyc == p + 20) begin
                button_raw[0] = 1'b0;
                rise_q.push_back(next_strobe(p + 30) + 13);
            end
        end
        checks++; if (fall_q.size() + rise_q.size() != 0) begin failures++; $display("FAIL runtime_timeout: got %0d pending expected 0", fall_q.size() + rise_q.size()); end
        checks++; if (soc_reset_n !== 1'b1) begin failures++; $display("FAIL runtime_final_soc: got %b expected 1", soc_reset_n); end
    endtask

    task automatic test_repress_hold();
        int   fall_q[$];
        int   rise_q[$];
        int   p, s1;
        logic prev_soc;
        @(negedge clock);
        p = cyc;
        button_raw[0] = 1'b1;
        fall_q.push_back(next_strobe(p + 10) + 1);
        s1 = next_strobe(p + 22);
        prev_soc = soc_reset_n;
        for (int i = 0; i < 110; i++) begin
            @(negedge clock);
            if (soc_reset_n !== prev_soc) begin
                int e;
                checks++;
                if (soc_reset_n === 1'b0) begin
                    if (fall_q.size() == 0) begin failures++; $display("FAIL repress_unexpected_fall: got fall at %0d expected none", cyc - p); end
                    else begin e = fall_q.pop_front(); if (cyc != e) begin failures++; $display("FAIL repress_fall_cycle: got %0d expected %0d", cyc - p, e - p); end end
                end else begin
                    if (rise_q.size() == 0) begin failures++; $display("FAIL repress_unexpected_rise: got rise at %0d expected none", cyc - p); end
                    else begin e = rise_q.pop_front(); if (cyc != e) begin failures++; $display("FAIL repress_rise_cycle: got %0d expected %0d", cyc - p, e - p); end end
                end
            end
            prev_soc = soc_reset_n;
            if (cyc == s1 + 12) begin
                checks++; if (button_debounced[0] !== 1'b1) begin failures++; $display("FAIL repress_debounced_at_strobe: got %b expected 1", button_debounced[0]); end
            end
            if (cyc == p + 12) button_raw[0] = 1'b0;
            if (cyc == s1) button_raw[0] = 1'b1;
            if (cyc == s1 + 14) begin
                button_raw[0] = 1'b0;
                rise_q.push_back(next_strobe(s1 + 24) + 13);
            end
        end
        checks++; if (fall_q.size() + rise_q.size() != 0) begin failures++; $display("FAIL repress_timeout: got %0d pending expected 0", fall_q.size() + rise_q.size()); end
    endtask

    task automatic test_async_reset();
        int   k;
        logic e_cd, e_soc;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rel_cyc = cyc;
        button_raw[3] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (cyc == rel_cyc + 8) button_raw[2] = 1'b1;
        end
        checks++; if (button_debounced[3] !== 1'b1) begin failures++; $display("FAIL async_pre_debounced3: got %b expected 1", button_debounced[3]); end
        checks++; if (clock_divided !== 1'b1) begin failures++; $display("FAIL async_pre_clock_divided: got %b expected 1", clock_divided); end
        checks++; if (soc_reset_n !== 1'b0) begin failures++; $display("FAIL async_pre_soc: got %b expected 0", soc_reset_n); end
        #2;
        reset = 1'b1;
        button_raw = '0;
        #1;
        checks++; if (clock_divided !== 1'b0) begin failures++; $display("FAIL async_clock_divided: got %b expected 0", clock_divided); end
        checks++; if (clock_divided_rise !== 1'b0) begin failures++; $display("FAIL async_rise: got %b expected 0", clock_divided_rise); end
        checks++; if (button_debounced !== '0) begin failures++; $display("FAIL async_debounced: got %b expected 0", button_debounced); end
        checks++; if (button_pressed !== '0) begin failures++; $display("FAIL async_pressed: got %b expected 0", button_pressed); end
        checks++; if (soc_reset_n !== 1'b0) begin failures++; $display("FAIL async_soc: got %b expected 0", soc_reset_n); end
        repeat (2) @(negedge clock);
        checks++; if ({clock_divided, clock_divided_rise, button_debounced, button_pressed, soc_reset_n} !== '0) begin
            failures++; $display("FAIL async_held: got %b expected 0", {clock_divided, clock_divided_rise, button_debounced, button_pressed, soc_reset_n});
        end
        reset = 1'b0;
        rel_cyc = cyc;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            k = cyc - rel_cyc;
            e_cd  = ((k / 2) % 2) == 1;
            e_soc = k >= 16;
            checks++; if (button_pressed !== '0 || button_debounced !== '0) begin failures++; $display("FAIL async_after_buttons k=%0d: got %b/%b expected 0/0", k, button_debounced, button_pressed); end
            checks++; if (clock_divided !== e_cd) begin failures++; $display("FAIL async_after_clock_divided k=%0d: got %b expected %b", k, clock_divided, e_cd); end
            checks++; if (soc_reset_n !== e_soc) begin failures++; $display("FAIL async_after_soc k=%0d: got %b expected %b", k, soc_reset_n, e_soc); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_glitch();
        test_clean_press();
        test_runtime_reset_button();
        test_repress_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
